hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports Rs1D, Rs2D, input, 5 bits each: source registers of the instruction in the D stage.
REQ-004 SHALL have ports Rs1E, Rs2E, RdE, input, 5 bits each: source and destination registers in the E stage.
REQ-005 SHALL have port ResultSrcE, input, 2 bits: value 2'b01 marks a load in the E stage.
REQ-006 SHALL have port PCSrcE, input, 1 bit: taken branch or jump resolved in the E stage.
REQ-007 SHALL have ports RdM (input, 5 bits), RegWriteM (input, 1 bit), ResultSrcM (input, 2 bits) and MemWriteM (input, 1 bit): M-stage destination and controls.
REQ-008 SHALL have ports RdW (input, 5 bits) and RegWriteW (input, 1 bit): W-stage destination and write enable.
REQ-009 SHALL have port dmem_ready, input, 1 bit: data memory completes the current access this cycle.
REQ-010 SHALL have ports ForwardAE, ForwardBE, output, 2 bits each: ALU operand select, 00 = register file, 01 = W result, 10 = M ALUResult.
REQ-011 SHALL have ports StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, output, 1 bit each: pipeline-register hold and bubble controls.
REQ-012 SHALL have port dmem_req, output, 1 bit: data memory access request.
REQ-013 SHALL have ports lu_cnt and mem_cnt, output, 16 bits each: saturating counters of load-use stall cycles and memory-wait cycles.

Function
REQ-014 SHALL define MemAccM = MemWriteM | (ResultSrcM == 2'b01).
REQ-015 SHALL set ForwardAE = 10 when RegWriteM, RdM != 0 and RdM == Rs1E; otherwise 01 when RegWriteW, RdW != 0 and RdW == Rs1E; otherwise 00. ForwardBE SHALL use the same rule with Rs2E. The M match SHALL take priority over the W match.
REQ-016 SHALL define lwStall = (ResultSrcE == 2'b01) & (RdE != 0) & (RdE == Rs1D | RdE == Rs2D) & ~PCSrcE. When a branch is taken, the D instruction is on the wrong path and SHALL NOT stall.
REQ-017 SHALL implement a memory FSM with two states, IDLE and WAIT.
  - IDLE -> WAIT when MemAccM & ~dmem_ready.
  - WAIT -> IDLE when dmem_ready.
  - Otherwise the FSM SHALL hold its state.
REQ-018 SHALL define memStall = MemAccM & ~dmem_ready, evaluated in both states.
REQ-019 SHALL drive dmem_req = MemAccM in both states, held high for the whole access; dmem_req SHALL be 0 when MemAccM = 0.
REQ-020 While memStall = 1, SHALL drive StallF = StallD = StallE = StallM = 1, FlushW = 1 and FlushD = FlushE = 0.
  - PCSrcE and lwStall effects are deferred until the stall releases, because the E stage is frozen.
REQ-021 While memStall = 0, SHALL drive:
  - StallF = StallD = lwStall;
  - FlushE = lwStall | PCSrcE;
  - FlushD = PCSrcE;
  - StallE = StallM = FlushW = 0.
REQ-022 All control and forwarding outputs SHALL be combinational from the current inputs; there is zero-cycle latency from a hazard to its stall or flush.
REQ-023 On each clock edge with lu_cnt < 16'hFFFF, lu_cnt SHALL increment when lwStall & ~memStall; at 16'hFFFF it SHALL hold.
REQ-024 On each clock edge with mem_cnt < 16'hFFFF, mem_cnt SHALL increment when memStall; at 16'hFFFF it SHALL hold.
REQ-025 If the FSM is in WAIT and MemAccM falls to 0 without dmem_ready (a protocol error), SHALL return to IDLE on the next edge and deassert dmem_req immediately.
REQ-026 When dmem_ready arrives in the same cycle as a new request, SHALL NOT stall; the access completes in that cycle.

Reset
REQ-027 When reset = 1 at a clock edge, SHALL set the FSM to IDLE and lu_cnt = mem_cnt = 0. Reset SHALL take priority over every other update, including a reset asserted in the middle of a WAIT.
REQ-028 While reset = 1, SHALL drive outputs from the inputs per REQ-015 to REQ-021. Combinational outputs are not masked by reset; the pipeline registers clear themselves on reset.

Verification
REQ-029 Load-use: ResultSrcE = 01, RdE = 5, Rs1D = 5, PCSrcE = 0, MemAccM = 0 -> StallF = StallD = FlushE = 1, FlushD = 0, and lu_cnt increases by 1 per cycle.
REQ-030 Forwarding priority: RegWriteM = RegWriteW = 1, RdM = RdW = Rs1E = 7 -> ForwardAE = 10; with RdM = 0 -> ForwardAE = 01; with Rs1E = 0 -> ForwardAE = 00.
REQ-031 Taken branch during load-use: PCSrcE = 1 with the REQ-029 inputs -> StallF = 0, FlushD = FlushE = 1, and lu_cnt unchanged.
REQ-032 Memory wait: MemWriteM = 1 with dmem_ready low for 3 cycles, then high ->
  - StallF/D/E/M = FlushW = 1 and dmem_req = 1 for 3 cycles;
  - FSM reaches WAIT, then IDLE after the ready cycle;
  - mem_cnt = 3.
REQ-033 Reset mid-WAIT: reset = 1 during the REQ-032 wait -> FSM = IDLE and both counters = 0 on the next edge.
REQ-034 Saturation: mem_cnt preloaded to 16'hFFFE by running the REQ-032 stimulus for 65534 cycles, then 3 more stall cycles -> mem_cnt = 16'hFFFF and held.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard unit: stage register fields and controls in,
// forwarding/stall/flush decisions, memory request and event counters out.
interface hazard_ctrl_if;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE;
  logic [4:0]  RdM;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [4:0]  RdW;
  logic        RegWriteW;
  logic        dmem_ready;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic        StallF;
  logic        StallD;
  logic        StallE;
  logic        StallM;
  logic        FlushD;
  logic        FlushE;
  logic        FlushW;
  logic        dmem_req;
  logic [15:0] lu_cnt;
  logic [15:0] mem_cnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RegWriteM, ResultSrcM, MemWriteM, RdW, RegWriteW, dmem_ready,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, dmem_req, lu_cnt, mem_cnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RegWriteM, ResultSrcM, MemWriteM, RdW, RegWriteW, dmem_ready,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, dmem_req, lu_cnt, mem_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use stall, branch flush,
// data-memory wait handling and saturating stall-event counters.
module hazard_ctrl (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic        state_q, state_d;
  logic [15:0] lu_cnt_q, lu_cnt_d;
  logic [15:0] mem_cnt_q, mem_cnt_d;
  logic        mem_acc_s, lw_stall_s, mem_stall_s;
  logic        dmem_req_s;
  logic        stall_f_s, stall_d_s, stall_e_s, stall_m_s;
  logic        flush_d_s, flush_e_s, flush_w_s;

  // M stage wins over W stage; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       wr_m,
    input logic [4:0] rd_m,
    input logic       wr_w,
    input logic [4:0] rd_w
  );
    logic [1:0] sel;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard conditions derived directly from the current stage fields
  always_comb begin
    mem_acc_s   = bus.MemWriteM | (bus.ResultSrcM == 2'b01);
    mem_stall_s = mem_acc_s & ~bus.dmem_ready;
    lw_stall_s  = (bus.ResultSrcE == 2'b01) & (bus.RdE != 5'd0) &
                  ((bus.RdE == bus.Rs1D) | (bus.RdE == bus.Rs2D)) & ~bus.PCSrcE;
  end

  // Memory FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory FSM next state; a dropped request in WAIT is treated as aborted
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_acc_s && !bus.dmem_ready) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!mem_acc_s || bus.dmem_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall/flush/request outputs; a memory wait freezes the whole pipe and defers E-stage effects
  always_comb begin
    dmem_req_s = 1'b0;
    stall_f_s  = 1'b0;
    stall_d_s  = 1'b0;
    stall_e_s  = 1'b0;
    stall_m_s  = 1'b0;
    flush_d_s  = 1'b0;
    flush_e_s  = 1'b0;
    flush_w_s  = 1'b0;
    case (state_q)
      ST_IDLE: dmem_req_s = mem_acc_s;
      ST_WAIT: dmem_req_s = mem_acc_s;
      default: dmem_req_s = mem_acc_s;
    endcase
    if (mem_stall_s) begin
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      stall_e_s = 1'b1;
      stall_m_s = 1'b1;
      flush_w_s = 1'b1;
    end else begin
      stall_f_s = lw_stall_s;
      stall_d_s = lw_stall_s;
      flush_e_s = lw_stall_s | bus.PCSrcE;
      flush_d_s = bus.PCSrcE;
    end
  end

  // Saturating counter next values
  always_comb begin
    lu_cnt_d  = lu_cnt_q;
    mem_cnt_d = mem_cnt_q;
    if (lw_stall_s && !mem_stall_s && (lu_cnt_q != CNT_MAX)) begin
      lu_cnt_d = lu_cnt_q + 16'd1;
    end else begin
      lu_cnt_d = lu_cnt_q;
    end
    if (mem_stall_s && (mem_cnt_q != CNT_MAX)) begin
      mem_cnt_d = mem_cnt_q + 16'd1;
    end else begin
      mem_cnt_d = mem_cnt_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      lu_cnt_q  <= 16'd0;
      mem_cnt_q <= 16'd0;
    end else begin
      lu_cnt_q  <= lu_cnt_d;
      mem_cnt_q <= mem_cnt_d;
    end
  end

  assign bus.ForwardAE = fwd_sel(bus.Rs1E, bus.RegWriteM, bus.RdM, bus.RegWriteW, bus.RdW);
  assign bus.ForwardBE = fwd_sel(bus.Rs2E, bus.RegWriteM, bus.RdM, bus.RegWriteW, bus.RdW);
  assign bus.StallF    = stall_f_s;
  assign bus.StallD    = stall_d_s;
  assign bus.StallE    = stall_e_s;
  assign bus.StallM    = stall_m_s;
  assign bus.FlushD    = flush_d_s;
  assign bus.FlushE    = flush_e_s;
  assign bus.FlushW    = flush_w_s;
  assign bus.dmem_req  = dmem_req_s;
  assign bus.lu_cnt    = lu_cnt_q;
  assign bus.mem_cnt   = mem_cnt_q;

endmodule
